// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring counter and its downstream monitor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ring_pkg;

    // Default ring pattern width
    localparam int RING_WIDTH = 8;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } ring_state_t;

    // One-bit left rotation; the MSB wraps into the LSB
    function automatic logic [RING_WIDTH-1:0] rotl1(input logic [RING_WIDTH-1:0] v);
        return {v[RING_WIDTH-2:0], v[RING_WIDTH-1]};
    endfunction

endpackage

// File: rtl/popcount.sv
// Combinational ones counter over a WIDTH-bit word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]           i_dat,
    output logic [$clog2(WIDTH+1)-1:0] o_cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    // Sum the set bits of the input word
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_cnt = o_cnt + CW'(i_dat[i]);
        end
    end

endmodule

// File: rtl/ring_monitor.sv
// Ring-pattern stream checker: acquires lock, counts revolutions, flags bad steps, sticky fault.
// Latency: 1 cycle; a sample taken at edge N is reflected on all outputs right after edge N.
// Backpressure: none; every en cycle is consumed. Optional popcount check: RING_MONITOR_POPCNT_EN.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = RING_WIDTH,
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] pat,
    input  logic             clr,
    output logic             locked,
    output logic             fault,
    output logic             step_err,
    output logic [REV_W-1:0] rev_cnt,
    output logic [7:0]       err_cnt
);

    localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);
    localparam int POS_W = $clog2(WIDTH);

    ring_state_t      r_state;
    logic [WIDTH-1:0] r_last;
    logic [RUN_W-1:0] r_run;
    logic [POS_W-1:0] r_pos;
    logic [REV_W-1:0] r_rev_cnt;
    logic [7:0]       r_err_cnt;
    logic             r_step_err;

    logic [WIDTH-1:0] w_rot;
    logic             w_rot_bad;
    logic             w_pc_bad;
    logic             w_cap_bad;
    logic             w_bad;
    logic [7:0]       w_err_inc;

    // Expected next pattern: reuse the shared rotate when widths agree
    if (WIDTH == RING_WIDTH) begin : g_pkg_rot
        assign w_rot = rotl1(r_last);
    end else begin : g_gen_rot
        assign w_rot = {r_last[WIDTH-2:0], r_last[WIDTH-1]};
    end

`ifdef RING_MONITOR_POPCNT_EN
    localparam int PC_W = $clog2(WIDTH + 1);
    logic [PC_W-1:0] w_pc;
    logic [PC_W-1:0] r_pc;

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .i_dat (pat),
        .o_cnt (w_pc)
    );

    assign w_pc_bad  = (w_pc != r_pc);
    assign w_cap_bad = (pat == '0);

    // Latch the ones count of the captured pattern; every later step must preserve it
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_pc <= '0;
        end else if (en && (r_state == ST_EMPTY) && !w_cap_bad) begin
            r_pc <= w_pc;
        end
    end
`else
    assign w_pc_bad  = 1'b0;
    assign w_cap_bad = 1'b0;
`endif

    assign w_rot_bad = (pat != w_rot);
    assign w_bad     = w_rot_bad | w_pc_bad;
    assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    // Monitor FSM with its counters; rst and clr both return to EMPTY with everything cleared
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state    <= ST_EMPTY;
            r_last     <= '0;
            r_run      <= '0;
            r_pos      <= '0;
            r_rev_cnt  <= '0;
            r_err_cnt  <= '0;
            r_step_err <= 1'b0;
        end else begin
            r_step_err <= 1'b0;
            if (en) begin
                r_last <= pat;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_cap_bad) begin
                            r_step_err <= 1'b1;
                            r_err_cnt  <= w_err_inc;
                        end else begin
                            r_state <= ST_ACQ;
                            r_run   <= '0;
                        end
                    end
                    ST_ACQ: begin
                        if (w_bad) begin
                            r_step_err <= 1'b1;
                            r_err_cnt  <= w_err_inc;
                            r_run      <= '0;
                        end else if (r_run == RUN_W'(LOCK_CNT - 1)) begin
                            r_state   <= ST_LOCKED;
                            r_run     <= '0;
                            r_pos     <= '0;
                            r_rev_cnt <= '0;
                        end else begin
                            r_run <= r_run + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_bad) begin
                            r_step_err <= 1'b1;
                            r_err_cnt  <= w_err_inc;
                            r_state    <= ST_FAULT;
                        end else if (r_pos == POS_W'(WIDTH - 1)) begin
                            r_pos     <= '0;
                            r_rev_cnt <= r_rev_cnt + 1'b1;
                        end else begin
                            r_pos <= r_pos + 1'b1;
                        end
                    end
                    default: begin
                        if (w_bad) begin
                            r_step_err <= 1'b1;
                            r_err_cnt  <= w_err_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign locked   = (r_state == ST_LOCKED);
    assign fault    = (r_state == ST_FAULT);
    assign step_err = r_step_err;
    assign rev_cnt  = r_rev_cnt;
    assign err_cnt  = r_err_cnt;

endmodule

// File: doc/ring_monitor.md
# ring_monitor

Checks the 8-bit rotating pattern stream produced by the ring counter stage. The stream advances by a one-bit left rotation (MSB wraps to LSB) on each sample. The block acquires the pattern and declares lock after a run of correct steps. It counts completed revolutions, flags any broken step, and holds a sticky fault once a locked stream breaks. It sits directly downstream of the ring counter and drives status LEDs and the board debug outputs.

## Interface
- WIDTH, 8: pattern width in bits.
- LOCK_CNT, 4: consecutive good steps needed to reach lock (≥1).
- REV_W, 8: width of the revolution counter.

- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  sample `pat` this cycle (connected to the ring counter's advance enable)
- pat  in  WIDTH  current ring pattern
- clr  in  1  clears state, counters and fault; synchronous
- locked  out  1  stream locked
- fault  out  1  sticky: a locked stream broke
- step_err  out  1  one-cycle pulse per bad step
- rev_cnt  out  REV_W  completed revolutions since lock; wraps modulo 2^REV_W
- err_cnt  out  8  bad steps; saturates at 255

## Operation
- Internal state: `last` (WIDTH), `run` (good-step counter), `pos` (0..WIDTH-1), FSM.
- FSM states and meaning:
  - EMPTY: no `last` captured yet.
  - ACQ: acquiring.
  - LOCKED: lock held.
  - FAULT: locked stream has broken.
- With en=0, nothing changes, except that `step_err` returns to 0.
- With en=1, the sample is classified as follows, and `last` <= pat in every state:
  - EMPTY: capture, then go to ACQ with run=0.
  - Good step: pat == {last[WIDTH-2:0], last[WIDTH-1]}. Any other value is a bad step.
- Transitions on a good step:
  - ACQ: run+1. When run reaches LOCK_CNT, go to LOCKED with pos=0 and rev_cnt=0.
  - LOCKED: pos+1. When pos wraps from WIDTH-1 to 0, rev_cnt+1.
  - FAULT: no change.
- Transitions on a bad step:
  - In all states: step_err=1 for one cycle, err_cnt+1 (saturating).
  - ACQ: run=0 and stay in ACQ.
  - LOCKED: go to FAULT.
  - FAULT: stay in FAULT.
- FAULT can only be left by clr or rst, both of which go to EMPTY.
- Periodic patterns (0x55, 0x00, 0xFF) are legal. Their rotation test is applied unchanged, with no special case.
- clr and en in the same cycle: clr wins and the sample is discarded.
- rst has priority over clr.

## Timing
- All outputs are registered. The response to a sample at edge N is visible after edge N.
- `locked` = (state==LOCKED). `fault` = (state==FAULT).
- Reset values: locked=0, fault=0, step_err=0, rev_cnt=0, err_cnt=0; state EMPTY.
- Lock latency: LOCK_CNT+1 enabled samples, counting the capture sample.
- Gaps in en are transparent. Comparison is always against the last enabled sample.
- A rst or clr asserted mid-revolution discards pos and the partial run.

## Configuration
- Macro `RING_MONITOR_POPCNT_EN`.
- When defined:
  - The EMPTY capture also latches popcount(pat).
  - A sample whose popcount differs from the latched value is a bad step, even if it passes the rotation test.
  - An all-zero capture is treated as a bad step, and the state stays EMPTY.
- When undefined: the rotation test only; no popcount logic is built.

## Structure
- Shared package `ring_pkg` holds:
  - the FSM state enum (EMPTY, ACQ, LOCKED, FAULT);
  - default WIDTH;
  - a `rotl1` function reused by the ring counter.
- One sub-module, `popcount`: a combinational WIDTH-bit ones counter, instantiated only under `RING_MONITOR_POPCNT_EN`.

## Test plan
- Lock:
  - Stimulus: after rst, feed 0x55, 0xAA, 0x55, 0xAA, 0x55 with en=1.
  - Required: locked=1 after the 5th sample; step_err never asserted.
- Revolution count:
  - Stimulus: feed 0x01 walking left for 5 samples to lock, then 16 more good samples.
  - Required: rev_cnt=2 and locked=1.
- Fault while locked:
  - Stimulus: after lock, feed 0x0F.
  - Required: a one-cycle step_err; fault=1, locked=0, err_cnt=1.
  - Then feed 12 valid steps: fault stays 1.
- clr priority:
  - Stimulus: assert clr and en together while in FAULT.
  - Required: next cycle state is EMPTY; fault=0, err_cnt=0, rev_cnt=0.
  - The following sample is a capture only, with no step_err.
- Saturation and gaps:
  - Feed 300 alternating bad samples in ACQ: err_cnt=255 and it holds there.
  - Insert 3-cycle en=0 gaps inside a valid sequence: lock latency is unchanged in enabled samples.
- Popcount (macro defined):
  - Stimulus: after capture of 0x03, feed 0x06, then 0x0E.
  - Required: 0x06 is good. 0x0E fails both tests: step_err=1 and err_cnt=1.
  - Capture of 0x00 gives step_err and the state stays EMPTY.
